johnson_ring: RTL and testbench

Parametrised synchronous ring-counter core: N registered stages in a shift ring with an inverting (Johnson) or non-inverting (rotate) feedback tap. It is the clocked, configurable generation of the free-running buffer/inverter ring benchmarks. It adds enable, seed load, a lock-up detector with optional self-correction, phase decode and a lap counter. It sits in the benchmark suite as a drop-in sequential ring for timing, period and fault-injection experiments.

---
 rtl/ring_pkg.sv | 19 +
 rtl/ring_decode.sv | 29 ++
 rtl/johnson_ring.sv | 66 ++++++
 tb/tb_johnson_ring.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared constants and helpers for the johnson_ring core and its decode logic.
package ring_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_ROTATE  = 1'b1;
  localparam int   MAX_N        = 64;

  function automatic int phase_width(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int popcount(input logic [MAX_N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ring_decode.sv
// Combinational legality check and phase decode of a Johnson ring state.
module ring_decode
  import ring_pkg::*;
#(
  parameter int N = 20
) (
  input  logic [N-1:0]                q,
  input  logic                        mode,
  output logic                        legal,
  output logic [phase_width(N)-1:0]   phase
);

  localparam int PW = phase_width(N);

  logic [N-2:0] edges;
  int           ones;
  int           steps;

  // A Johnson state is one run of ones and one run of zeros: at most one interior edge.
  assign edges = q[N-2:0] ^ q[N-1:1];

  always_comb begin
    ones  = popcount(MAX_N'(q));
    steps = popcount(MAX_N'(edges));
    legal = (mode == MODE_ROTATE) || (steps <= 1);
    phase = q[N-1] ? PW'(2 * N - ones) : PW'(ones);
  end

endmodule

// File: rtl/johnson_ring.sv
// Configurable Johnson/rotate ring with seed load, lock-up correction and lap counting.
module johnson_ring
  import ring_pkg::*;
#(
  parameter int N       = 20,
  parameter int CW      = 16,
  parameter int AUTOFIX = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [N-1:0]                seed,
  input  logic                        mode,
  output logic [N-1:0]                q,
  output logic [phase_width(N)-1:0]   phase,
  output logic                        legal,
  output logic                        fix_pulse,
  output logic [CW-1:0]               laps,
  output logic                        lap_pulse
);

  localparam int              PW         = phase_width(N);
  localparam logic [PW-1:0]   LAST_PHASE = PW'(2 * N - 1);

  logic fb;
  logic fix;
  logic lap;

  ring_decode #(.N(N)) u_decode (
    .q     (q),
    .mode  (mode),
    .legal (legal),
    .phase (phase)
  );

  assign fb  = (mode == MODE_ROTATE) ? q[N-1] : ~q[N-1];
  assign fix = (AUTOFIX != 0) && (mode == MODE_JOHNSON) && !legal && !load;
  // A lap closes on the step out of the last phase; loads and corrections never count.
  assign lap = (mode == MODE_JOHNSON) && en && !load && !fix && (phase == LAST_PHASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      laps      <= '0;
      fix_pulse <= 1'b0;
      lap_pulse <= 1'b0;
    end else begin
      fix_pulse <= 1'b0;
      lap_pulse <= 1'b0;
      if (load) begin
        q <= seed;
      end else if (fix) begin
        q         <= '0;
        fix_pulse <= 1'b1;
      end else if (en) begin
        q <= {q[N-2:0], fb};
      end
      if (lap) begin
        laps      <= laps + CW'(1);
        lap_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_ring.sv
// Scoreboard bench for johnson_ring: independent pattern-table model, expectations queued per cycle.
module tb_johnson_ring;

  localparam int N       = 20;
  localparam int CW      = 16;
  localparam int AUTOFIX = 1;
  localparam int PW      = $clog2(2 * N);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic [N-1:0]  seed;
  logic          mode;
  logic [N-1:0]  q;
  logic [PW-1:0] phase;
  logic          legal;
  logic          fix_pulse;
  logic [CW-1:0] laps;
  logic          lap_pulse;

  johnson_ring #(.N(N), .CW(CW), .AUTOFIX(AUTOFIX)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .seed      (seed),
    .mode      (mode),
    .q         (q),
    .phase     (phase),
    .legal     (legal),
    .fix_pulse (fix_pulse),
    .laps      (laps),
    .lap_pulse (lap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  q;
    logic [CW-1:0] laps;
    logic          fix;
    logic          lap;
    logic          legal;
    int            ph;
  } exp_t;

  exp_t          sb[$];
  logic [N-1:0]  mq;
  logic [CW-1:0] mlaps;
  int            n_checks = 0;
  int            n_errors = 0;
  int            lap_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Phase index by matching against the enumerated Johnson sequence; -1 if not a Johnson state.
  function automatic int jidx(input logic [N-1:0] v);
    logic [N-1:0] ones;
    logic [N-1:0] pat;
    ones = '1;
    for (int k = 0; k < 2 * N; k++) begin
      if (k <= N) pat = ~(ones << k);
      else        pat = ones << (k - N);
      if (v == pat) return k;
    end
    return -1;
  endfunction

  task automatic cycle(input logic i_en, input logic i_load, input logic [N-1:0] i_seed,
                       input logic i_mode);
    exp_t e;
    int   idx;
    logic cur_legal, mfix, mlap;
    en   = i_en;
    load = i_load;
    seed = i_seed;
    mode = i_mode;
    idx       = jidx(mq);
    cur_legal = i_mode || (idx >= 0);
    mfix = !i_mode && (AUTOFIX != 0) && !cur_legal && !i_load;
    mlap = !i_mode && i_en && !i_load && !mfix && (idx == 2 * N - 1);
    if (i_load)    mq = i_seed;
    else if (mfix) mq = '0;
    else if (i_en) mq = {mq[N-2:0], i_mode ? mq[N-1] : ~mq[N-1]};
    if (mlap) mlaps = mlaps + 1'b1;
    e.q     = mq;
    e.laps  = mlaps;
    e.fix   = mfix;
    e.lap   = mlap;
    e.legal = i_mode || (jidx(mq) >= 0);
    e.ph    = i_mode ? -1 : jidx(mq);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("q", q, e.q);
    check("laps", laps, e.laps);
    check("fix_pulse", fix_pulse, e.fix);
    check("lap_pulse", lap_pulse, e.lap);
    check("legal", legal, e.legal);
    if (e.ph >= 0) check("phase", phase, e.ph);
    if (lap_pulse) lap_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0; mode = 1'b0;
    mq = '0; mlaps = '0; lap_seen = 0;
    #23;
    check("rst_q", q, 0);
    check("rst_laps", laps, 0);
    check("rst_phase", phase, 0);
    check("rst_legal", legal, 1);
    check("rst_pulses", {fix_pulse, lap_pulse}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Free-running Johnson: one full period of 2N cycles.
    for (int i = 1; i <= 2 * N; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      check("run_phase", phase, i % (2 * N));
      if (i == N) check("run_all_ones", q, 20'hFFFFF);
    end
    check("run_lap_count", lap_seen, 1);
    check("run_lap_last", lap_pulse, 1);
    check("run_laps", laps, 1);

    // Hold with en low at phase 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    lap_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      check("hold_phase", phase, 7);
      check("hold_fix", fix_pulse, 0);
    end
    check("hold_laps_seen", lap_seen, 0);

    // load beats en.
    cycle(1'b1, 1'b1, 20'h000FF, 1'b0);
    check("load_en_q", q, 20'h000FF);
    check("load_en_phase", phase, 8);

    // Illegal seed: flagged one cycle, then corrected.
    cycle(1'b0, 1'b1, 20'h00005, 1'b0);
    check("bad_q", q, 20'h00005);
    check("bad_legal", legal, 0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("fix_q", q, 0);
    check("fix_pulse_hi", fix_pulse, 1);
    check("fix_laps", laps, 1);

    // Rotate mode: single bit circulates, no laps.
    lap_seen = 0;
    cycle(1'b1, 1'b1, 20'h00001, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("rot_q", q, 20'h00001);
    check("rot_laps", laps, 1);
    check("rot_laps_seen", lap_seen, 0);

    // Run to phase 39 and reset just before the lap would close.
    cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 2 * N - 1; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    check("pre_rst_phase", phase, 2 * N - 1);
    en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    mq = '0;
    mlaps = '0;
    check("arst_q", q, 0);
    check("arst_laps", laps, 0);
    @(posedge clk);
    #1;
    check("arst_lap_pulse", lap_pulse, 0);
    check("arst_q_hold", q, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      check("restart_phase", phase, i);
    end
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
